decode_sequencer: RTL and testbench



---
 rtl/decode_sequencer.sv | 175 +++++++++++++++++
 tb/tb_decode_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Bytecode front-end: fetches words, drives the decoder handshake and buffers micro-ops.
// Define DECSEQ_HALT_ON_RETURN_EN to halt at ireturn (0xAC) / dreturn (0xAF) boundaries.
module decode_sequencer #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 32,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 4,
    parameter int MAX_UOPS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [ADDR_W-1:0]    pc_init,
    input  logic                 stop,
    output logic                 busy,
    output logic [ADDR_W-1:0]    pc,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [WIDTH_IN-1:0]  imem_data,
    output logic                 dec_start,
    output logic [WIDTH_IN-1:0]  dec_instr,
    input  logic                 dec_ready,
    input  logic                 dec_uop_valid,
    input  logic [WIDTH_OUT-1:0] dec_uop,
    output logic                 uop_valid,
    output logic [WIDTH_OUT-1:0] uop_data,
    input  logic                 uop_accept,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(DEPTH - MAX_UOPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DEC_ACK,
        S_DEC_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [WIDTH_IN-1:0]  instr_q, instr_d;
    logic                 stop_q, stop_d;
    logic                 start_q, start_d;
    logic                 ovf_q, ovf_d;
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH_OUT-1:0] mem_q [DEPTH];
    logic                 push, pop, full, room, ret_hit;

`ifdef DECSEQ_HALT_ON_RETURN_EN
    logic [7:0] opcode;
    assign opcode  = instr_q[WIDTH_IN-1 -: 8];
    assign ret_hit = (opcode == 8'hAC) || (opcode == 8'hAF);
`else
    assign ret_hit = 1'b0;
`endif

    assign full = (cnt_q == FULL_CNT);
    assign pop  = (cnt_q != '0) && uop_accept;
    // A push into a full buffer still lands when the head leaves the same cycle.
    assign push = dec_uop_valid && (!full || pop);
    assign room = (cnt_q <= ISSUE_MAX);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        stop_d  = stop_q;
        start_d = 1'b0;
        if (state_q != S_IDLE && stop) begin
            stop_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    pc_d    = pc_init;
                    stop_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (room && dec_ready) begin
                    start_d = 1'b1;
                    state_d = S_DEC_ACK;
                end
            end
            S_DEC_ACK: begin
                if (!dec_ready) begin
                    state_d = S_DEC_RUN;
                end
            end
            S_DEC_RUN: begin
                if (dec_ready) begin
                    if (stop_q || stop || ret_hit) begin
                        state_d = S_IDLE;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_q;
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (dec_uop_valid && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            stop_q  <= 1'b0;
            start_q <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            stop_q  <= stop_d;
            start_q <= start_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            if (push) begin
                mem_q[wr_q] <= dec_uop;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign pc        = pc_q;
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign dec_start = start_q;
    assign dec_instr = instr_q;
    assign uop_valid = (cnt_q != '0);
    assign uop_data  = mem_q[rd_q];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer with behavioural memory and decoder models.
module tb_decode_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, stop;
    logic [15:0] pc_init;
    logic        busy, imem_req, imem_ack;
    logic [15:0] pc, imem_addr, imem_data;
    logic        dec_start, dec_ready, dec_uop_valid;
    logic [15:0] dec_instr;
    logic [31:0] dec_uop;
    logic        uop_valid, uop_accept, overflow;
    logic [31:0] uop_data;

    logic        dvalid = 1'b0, fvalid = 1'b0;
    logic [31:0] ddata = '0, fdata = '0;
    logic        acc_m = 1'b0, acc_r = 1'b0, acc_rand = 1'b0;

    assign dec_uop_valid = dvalid | fvalid;
    assign dec_uop       = fvalid ? fdata : ddata;
    assign uop_accept    = acc_rand ? acc_r : acc_m;

    decode_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .pc_init(pc_init),
        .stop(stop), .busy(busy), .pc(pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .dec_start(dec_start),
        .dec_instr(dec_instr), .dec_ready(dec_ready),
        .dec_uop_valid(dec_uop_valid), .dec_uop(dec_uop),
        .uop_valid(uop_valid), .uop_data(uop_data),
        .uop_accept(uop_accept), .overflow(overflow)
    );

    int          checks = 0, errors = 0;
    logic [31:0] expq[$];
    logic [15:0] prog [0:255];
    logic [15:0] exp_pc = '0, last_fetch = '0, iw;
    int          fetch_cnt = 0, start_cnt = 0;
    int          ack_dly = 1, wait_cnt = 0;
    logic        ack_hold = 1'b0, rand_dly = 1'b0;

    function automatic logic [31:0] uop_of(logic [15:0] w, int k);
        logic [15:0] kk;
        kk = 16'(k);
        return {w, kk ^ 16'h5A3C};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Instruction memory: acks ack_dly cycles after a request is seen.
    always begin
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        if (!reset) begin
            wait_cnt = 0;
        end else if (imem_req && !ack_hold) begin
            if (wait_cnt < ack_dly) begin
                wait_cnt++;
            end else begin
                chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
                imem_data = prog[imem_addr[7:0]];
                imem_ack  = 1'b1;
                iw = prog[exp_pc[7:0]];
                for (int k = 0; k < 1 + int'(iw[0]); k++) begin
                    expq.push_back(uop_of(iw, k));
                end
                last_fetch = exp_pc;
                exp_pc     = exp_pc + 16'd1;
                fetch_cnt++;
                wait_cnt = 0;
                if (rand_dly) ack_dly = $urandom_range(0, 2);
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Decoder: 1 + instr[0] micro-ops after a random delay.
    int          dst = 0, dwait = 0, dk = 0, dn = 0;
    logic [15:0] dinstr = '0;
    initial dec_ready = 1'b1;
    always begin
        @(posedge clk);
        #1;
        dvalid = 1'b0;
        if (!reset) begin
            dst       = 0;
            dec_ready = 1'b1;
        end else if (dst == 0) begin
            if (dec_start) begin
                chk("dec_instr", 32'(dec_instr), 32'(prog[last_fetch[7:0]]));
                dinstr    = dec_instr;
                dec_ready = 1'b0;
                dwait     = $urandom_range(0, 2);
                dk        = 0;
                dn        = 1 + int'(dinstr[0]);
                dst       = 1;
            end
        end else if (dwait > 0) begin
            dwait--;
        end else if (dk < dn) begin
            dvalid = 1'b1;
            ddata  = uop_of(dinstr, dk);
            dk++;
        end else begin
            dec_ready = 1'b1;
            dst       = 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        acc_r = 1'($urandom_range(0, 1));
    end

    // Monitor: compares the buffer head whenever a pop is about to happen.
    always @(negedge clk) begin
        if (dec_start) start_cnt++;
        if (reset && uop_valid && uop_accept) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uop_extra: got %h expected none", uop_data);
            end else begin
                chk("uop_data", uop_data, expq.pop_front());
            end
        end
    end

    task automatic wait_fetch(int n, int budget);
        int c = 0;
        while (fetch_cnt < n && c < budget) begin tick; c++; end
        checks++;
        if (fetch_cnt < n) begin
            errors++;
            $display("FAIL wait_fetch: got %0d expected %0d", fetch_cnt, n);
        end
    endtask

    task automatic wait_idle(int budget);
        int c = 0;
        while (busy && c < budget) begin tick; c++; end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_dec_busy(int budget);
        int c = 0;
        while (dec_ready && c < budget) begin tick; c++; end
        chk("wait_dec_busy", 32'(dec_ready), 32'd0);
    endtask

    task automatic wait_req(int budget);
        int c = 0;
        while (!imem_req && c < budget) begin tick; c++; end
        chk("wait_req", 32'(imem_req), 32'd1);
    endtask

    task automatic wait_drain(int budget);
        int c = 0;
        while (expq.size() != 0 && c < budget) begin tick; c++; end
        chk("drain_left", 32'(expq.size()), 32'd0);
        chk("drain_uop_valid", 32'(uop_valid), 32'd0);
    endtask

    task automatic do_run(logic [15:0] a);
        pc_init = a;
        exp_pc  = a;
        run     = 1'b1;
        tick;
        run     = 1'b0;
    endtask

    task automatic do_stop;
        stop = 1'b1;
        tick;
        stop = 1'b0;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_dec_start"}, 32'(dec_start), 32'd0);
        chk({tag, "_uop_valid"}, 32'(uop_valid), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_dec_instr"}, 32'(dec_instr), 32'd0);
    endtask

    initial begin
        int   s0;
        logic req_seen;
        logic [7:0] op;
        logic [15:0] base;
        reset = 1'b0; run = 1'b0; stop = 1'b0; pc_init = '0;
        imem_ack = 1'b0; imem_data = '0;
        for (int i = 0; i < 256; i++) prog[i] = {8'h60, 8'(i * 2)};
        tick;
        tick;
        chk_reset_state("rst");
        reset = 1'b1;
        tick;

        // Sequential fetch, one micro-op each.
        acc_m = 1'b1; ack_dly = 1; fetch_cnt = 0;
        do_run(16'h0010);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_imem_req", 32'(imem_req), 32'd1);
        chk("run_pc", 32'(pc), 32'h10);
        wait_fetch(3, 100);
        do_stop;
        wait_idle(100);
        chk("a_pc", 32'(pc), 32'h12);
        chk("a_fetches", 32'(fetch_cnt), 32'd3);
        chk("a_overflow", 32'(overflow), 32'd0);
        wait_drain(50);

        // Two micro-ops each with no consumer: issue must stall.
        for (int i = 8'h40; i < 8'h50; i++) prog[i] = {8'h60, 8'(i * 2 + 1)};
        acc_m = 1'b0; fetch_cnt = 0; s0 = start_cnt;
        do_run(16'h0040);
        wait_fetch(3, 100);
        repeat (12) tick;
        chk("b_starts_stalled", 32'(start_cnt - s0), 32'd2);
        chk("b_overflow", 32'(overflow), 32'd0);
        chk("b_uop_valid", 32'(uop_valid), 32'd1);
        acc_m = 1'b1;
        wait_fetch(4, 100);
        chk("b_starts_resumed", 32'(start_cnt - s0), 32'd3);
        do_stop;
        wait_idle(100);
        wait_drain(50);

        // Forced pushes: fill, push+pop while full, then overflow.
        acc_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fvalid = 1'b1;
            fdata  = 32'hC0DE_0000 + 32'(k);
            expq.push_back(fdata);
            tick;
        end
        fvalid = 1'b0;
        chk("c_full_valid", 32'(uop_valid), 32'd1);
        chk("c_full_ovf", 32'(overflow), 32'd0);
        fvalid = 1'b1; fdata = 32'hC0DE_0004; acc_m = 1'b1;
        expq.push_back(fdata);
        tick;
        fvalid = 1'b0; acc_m = 1'b0;
        chk("c_pushpop_ovf", 32'(overflow), 32'd0);
        fvalid = 1'b1; fdata = 32'hDEAD_BEEF;
        tick;
        fvalid = 1'b0;
        chk("c_ovf_set", 32'(overflow), 32'd1);
        repeat (3) tick;
        chk("c_ovf_sticky", 32'(overflow), 32'd1);
        acc_m = 1'b1;
        wait_drain(20);
        chk("c_ovf_after_drain", 32'(overflow), 32'd1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        chk("c_ovf_cleared", 32'(overflow), 32'd0);

        // Stop while the decode of 0x0020 is running.
        prog[8'h20] = 16'h6020; fetch_cnt = 0;
        do_run(16'h0020);
        wait_dec_busy(50);
        tick;
        do_stop;
        wait_idle(50);
        chk("d_pc", 32'(pc), 32'h20);
        chk("d_fetches", 32'(fetch_cnt), 32'd1);
        req_seen = 1'b0;
        repeat (8) begin
            tick;
            if (imem_req) req_seen = 1'b1;
        end
        chk("d_no_req", 32'(req_seen), 32'd0);
        chk("d_busy", 32'(busy), 32'd0);
        wait_drain(20);

        // Return opcode at 0x0005.
        prog[8'h05] = 16'hAC00; prog[8'h06] = 16'h6006; fetch_cnt = 0;
        do_run(16'h0005);
`ifdef DECSEQ_HALT_ON_RETURN_EN
        wait_idle(60);
        chk("e_pc", 32'(pc), 32'h5);
        chk("e_fetches", 32'(fetch_cnt), 32'd1);
`else
        wait_fetch(2, 60);
        chk("e_next_fetch", 32'(last_fetch), 32'h6);
        do_stop;
        wait_idle(60);
        chk("e_pc", 32'(pc), 32'h6);
`endif
        wait_drain(20);

        // Reset during a fetch with two micro-ops buffered.
        prog[8'h30] = 16'h6031; acc_m = 1'b0; ack_dly = 0; fetch_cnt = 0;
        do_run(16'h0030);
        wait_fetch(1, 50);
        ack_hold = 1'b1;
        wait_dec_busy(50);
        wait_req(50);
        chk("f_buffered", 32'(uop_valid), 32'd1);
        reset = 1'b0;
        tick;
        chk_reset_state("f");
        expq.delete();
        reset = 1'b1; ack_hold = 1'b0; ack_dly = 1; acc_m = 1'b1;
        fetch_cnt = 0;
        tick;
        do_run(16'h0010);
        wait_fetch(2, 60);
        do_stop;
        wait_idle(60);
        chk("f_restart_pc", 32'(pc), 32'h11);
        wait_drain(30);

        // Random programs, delays and consumer back-pressure.
        rand_dly = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                op = 8'($urandom);
                if (op == 8'hAC || op == 8'hAF) op = 8'h60;
                prog[i] = {op, 8'($urandom)};
            end
            base = (r == 0) ? 16'hFFFE : 16'($urandom);
            acc_rand = 1'b1; fetch_cnt = 0;
            do_run(base);
            chk("g_pc_init", 32'(pc), 32'(base));
            repeat ($urandom_range(20, 60)) tick;
            do_stop;
            wait_idle(200);
            chk("g_pc_final", 32'(pc), 32'(last_fetch));
            acc_rand = 1'b0; acc_m = 1'b1;
            wait_drain(40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
